// File: rtl/fc_requant_pkg.sv
// Shared types and helpers for layer post-processing.
//   state_e          : sequencing states of the requant block
//   prod_width()     : width of a signed-acc x unsigned-mult product
//   round_shift_sat(): rounding arithmetic right shift, optional ReLU, saturation
package fc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  // Working width of round_shift_sat; products must be at most CalcWidth-1 bits.
  localparam int unsigned CalcWidth = 64;

  // Signed acc times zero-extended unsigned mult needs one extra bit.
  function automatic int unsigned prod_width(input int unsigned acc_w,
                                             input int unsigned mult_w);
    return acc_w + mult_w + 1;
  endfunction

  // prod is the product sign-extended to CalcWidth. The rounding constant 2^(shift-1) is
  // only added while it fits the product-plus-one-bit sum; beyond that the result is just
  // the sign (0 or -1). Result is sign-extended to CalcWidth, already in activation range.
  function automatic logic signed [CalcWidth-1:0] round_shift_sat(
    input logic signed [CalcWidth-1:0] prod,
    input logic        [7:0]           shift,
    input int unsigned                 prod_w,
    input int unsigned                 act_w,
    input logic                        relu_en
  );
    logic signed [CalcWidth-1:0] rnd;
    logic signed [CalcWidth-1:0] r;
    logic signed [CalcWidth-1:0] hi;
    logic signed [CalcWidth-1:0] lo;
    rnd = '0;
    if (shift != 8'd0 && (32'(shift) - 32'd1) < prod_w) begin
      rnd = 64'sd1 <<< (shift - 8'd1);
    end
    r = (prod + rnd) >>> shift;
    if (relu_en && r < 0) begin
      r = '0;
    end
    hi = (64'sd1 <<< (act_w - 32'd1)) - 64'sd1;
    lo = -(64'sd1 <<< (act_w - 32'd1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/fc_requant_if.sv
// Bundle between the fully connected layer and its requant stage.
//   start/acc_in/mult/shift : run request and operands (driven by master)
//   busy/done               : progress; done is a one-cycle pulse
//   act_out/max_idx/max_val : activation vector and its argmax (driven by slave)
interface fc_requant_if #(
  parameter int unsigned NUM_ELEMS   = 10,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned ACT_WIDTH   = 8,
  parameter int unsigned MULT_WIDTH  = 16,
  parameter int unsigned SHIFT_WIDTH = 6
) ();

  localparam int unsigned IdxW = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;

  logic                                 start;
  logic [NUM_ELEMS-1:0][ACC_WIDTH-1:0]  acc_in;
  logic [MULT_WIDTH-1:0]                mult;
  logic [SHIFT_WIDTH-1:0]               shift;
  logic                                 busy;
  logic                                 done;
  logic [NUM_ELEMS-1:0][ACT_WIDTH-1:0]  act_out;
  logic [IdxW-1:0]                      max_idx;
  logic [ACT_WIDTH-1:0]                 max_val;

  modport master (
    output start, acc_in, mult, shift,
    input  busy, done, act_out, max_idx, max_val
  );

  modport slave (
    input  start, acc_in, mult, shift,
    output busy, done, act_out, max_idx, max_val
  );

endinterface

// File: rtl/fc_requant_requant_unit.sv
// Combinational stage-2 datapath: rounding right shift of a product, optional ReLU,
// saturation to a signed activation.
//   prod_i  : signed product
//   shift_i : right-shift amount
//   act_o   : saturated signed activation
module requant_unit
  import fc_pkg::*;
#(
  parameter int unsigned ProdWidth  = 49,
  parameter int unsigned ActWidth   = 8,
  parameter int unsigned ShiftWidth = 6,
  parameter bit          ReluEn     = 1'b1
) (
  input  logic signed [ProdWidth-1:0]  prod_i,
  input  logic        [ShiftWidth-1:0] shift_i,
  output logic signed [ActWidth-1:0]   act_o
);

  logic signed [CalcWidth-1:0] prod_ext;
  logic signed [CalcWidth-1:0] res;
  logic                        unused_res_hi;

  always_comb begin
    prod_ext = {{(CalcWidth - ProdWidth){prod_i[ProdWidth-1]}}, prod_i};
    res      = round_shift_sat(prod_ext, 8'(shift_i), ProdWidth, ActWidth, ReluEn);
    act_o    = res[ActWidth-1:0];
  end

  // Upper bits are a pure sign extension after saturation.
  assign unused_res_hi = ^res[CalcWidth-1:ActWidth];

endmodule

// File: rtl/fc_requant.sv
// Requantizes a fully connected layer's accumulator vector to signed activations and
// tracks their argmax. Elements stream through a 2-stage pipeline, one per cycle.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : slave side of fc_requant_if (start/operands in, results/status out)
module fc_requant
  import fc_pkg::*;
#(
  parameter int unsigned NUM_ELEMS   = 10,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned ACT_WIDTH   = 8,
  parameter int unsigned MULT_WIDTH  = 16,
  parameter int unsigned SHIFT_WIDTH = 6,
  parameter bit          RELU_EN     = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  fc_requant_if.slave bus
);

  localparam int unsigned     ProdW   = prod_width(ACC_WIDTH, MULT_WIDTH);
  localparam int unsigned     IdxW    = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_ELEMS - 1);

  state_e                              state_q, state_d;
  logic [NUM_ELEMS-1:0][ACC_WIDTH-1:0] acc_q, acc_d;
  logic [MULT_WIDTH-1:0]               mult_q, mult_d;
  logic [SHIFT_WIDTH-1:0]              shift_q, shift_d;
  logic [IdxW-1:0]                     idx_q, idx_d;

  logic                                s1_valid_q, s1_valid_d;
  logic [IdxW-1:0]                     s1_idx_q, s1_idx_d;
  logic signed [ProdW-1:0]             s1_prod_q, s1_prod_d;

  logic [NUM_ELEMS-1:0][ACT_WIDTH-1:0] act_q, act_d;
  logic [IdxW-1:0]                     max_idx_q, max_idx_d;
  logic signed [ACT_WIDTH-1:0]         max_val_q, max_val_d;

  logic                                accept;
  logic [ACC_WIDTH-1:0]                acc_sel;
  logic signed [ACT_WIDTH-1:0]         s2_act;

  // start only counts while no run is in flight.
  assign accept = bus.start && (state_q == StIdle || state_q == StDone);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (idx_q == LastIdx) state_d = StDrain;
      StDrain: if (s1_valid_q && s1_idx_q == LastIdx) state_d = StDone;
      StDone:  state_d = accept ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Operand capture and stage-1 issue counter.
  always_comb begin
    acc_d   = acc_q;
    mult_d  = mult_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    if (accept) begin
      acc_d   = bus.acc_in;
      mult_d  = bus.mult;
      shift_d = bus.shift;
      idx_d   = '0;
    end else if (state_q == StRun) begin
      idx_d = idx_q + IdxW'(1);
    end
  end

  // Stage 1: signed acc times zero-extended mult, both widened to the product width.
  always_comb begin
    acc_sel    = acc_q[idx_q];
    s1_valid_d = (state_q == StRun);
    s1_idx_d   = idx_q;
    s1_prod_d  = s1_prod_q;
    if (state_q == StRun) begin
      s1_prod_d = $signed({{(MULT_WIDTH + 1){acc_sel[ACC_WIDTH-1]}}, acc_sel}) *
                  $signed({{ACC_WIDTH{1'b0}}, 1'b0, mult_q});
    end
  end

  requant_unit #(
    .ProdWidth  (ProdW),
    .ActWidth   (ACT_WIDTH),
    .ShiftWidth (SHIFT_WIDTH),
    .ReluEn     (RELU_EN)
  ) u_requant_unit (
    .prod_i  (s1_prod_q),
    .shift_i (shift_q),
    .act_o   (s2_act)
  );

  // Stage 2 write-back and running argmax; element 0 always seeds the max, later ones
  // must be strictly greater so ties keep the lowest index.
  always_comb begin
    act_d     = act_q;
    max_idx_d = max_idx_q;
    max_val_d = max_val_q;
    if (accept) begin
      max_idx_d = '0;
      max_val_d = '0;
    end
    if (s1_valid_q) begin
      act_d[s1_idx_q] = s2_act;
      if (s1_idx_q == '0 || s2_act > max_val_q) begin
        max_idx_d = s1_idx_q;
        max_val_d = s2_act;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      mult_q     <= '0;
      shift_q    <= '0;
      idx_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      s1_prod_q  <= '0;
      act_q      <= '0;
      max_idx_q  <= '0;
      max_val_q  <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mult_q     <= mult_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      s1_valid_q <= s1_valid_d;
      s1_idx_q   <= s1_idx_d;
      s1_prod_q  <= s1_prod_d;
      act_q      <= act_d;
      max_idx_q  <= max_idx_d;
      max_val_q  <= max_val_d;
    end
  end

  assign bus.busy    = (state_q == StRun) || (state_q == StDrain);
  assign bus.done    = (state_q == StDone);
  assign bus.act_out = act_q;
  assign bus.max_idx = max_idx_q;
  assign bus.max_val = max_val_q;

endmodule

// File: tb/tb_fc_requant.sv
// Self-checking bench for fc_requant: one instance without and one with ReLU, driven
// with identical stimulus and compared against an arithmetic reference model.
module tb_fc_requant;

  localparam int N    = 4;
  localparam int ACC  = 32;
  localparam int ACT  = 8;
  localparam int MULT = 16;
  localparam int SH   = 6;

  logic clk;
  logic rst_n;

  fc_requant_if #(.NUM_ELEMS(N), .ACC_WIDTH(ACC), .ACT_WIDTH(ACT), .MULT_WIDTH(MULT),
                  .SHIFT_WIDTH(SH)) bus0 ();
  fc_requant_if #(.NUM_ELEMS(N), .ACC_WIDTH(ACC), .ACT_WIDTH(ACT), .MULT_WIDTH(MULT),
                  .SHIFT_WIDTH(SH)) bus1 ();

  fc_requant #(.NUM_ELEMS(N), .ACC_WIDTH(ACC), .ACT_WIDTH(ACT), .MULT_WIDTH(MULT),
               .SHIFT_WIDTH(SH), .RELU_EN(1'b0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  fc_requant #(.NUM_ELEMS(N), .ACC_WIDTH(ACC), .ACT_WIDTH(ACT), .MULT_WIDTH(MULT),
               .SHIFT_WIDTH(SH), .RELU_EN(1'b1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  longint      cur_acc[N];
  longint      cur_mult;
  int unsigned cur_shift;
  longint      exp_act[2][N];
  longint      exp_idx[2];
  longint      exp_val[2];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Real-number definition: round(p / 2^s) with halves toward +inf, via floor division.
  function automatic longint model_elem(input longint a, input longint m, input int unsigned s,
                                        input bit relu);
    longint p, num, den, q;
    p = a * m;
    if (s == 0) begin
      q = p;
    end else if (s < 50) begin
      num = p + (longint'(1) << (s - 1));
      den = longint'(1) << s;
      q   = num / den;
      if ((num % den) != 0 && num < 0) q = q - 1;
    end else begin
      // Shift beyond product width: result is the sign only.
      q = (p < 0) ? -1 : 0;
    end
    if (relu && q < 0) q = 0;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return q;
  endfunction

  task automatic compute_expected();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) exp_act[r][i] = model_elem(cur_acc[i], cur_mult, cur_shift, r == 1);
      exp_idx[r] = 0;
      exp_val[r] = exp_act[r][0];
      for (int i = 1; i < N; i++) begin
        if (exp_act[r][i] > exp_val[r]) begin
          exp_idx[r] = i;
          exp_val[r] = exp_act[r][i];
        end
      end
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      bus0.acc_in[i] = cur_acc[i][ACC-1:0];
      bus1.acc_in[i] = cur_acc[i][ACC-1:0];
    end
    bus0.mult  = cur_mult[MULT-1:0];
    bus1.mult  = cur_mult[MULT-1:0];
    bus0.shift = SH'(cur_shift);
    bus1.shift = SH'(cur_shift);
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < N; i++) begin
      bus0.acc_in[i] = $urandom();
      bus1.acc_in[i] = bus0.acc_in[i];
    end
    bus0.mult  = MULT'($urandom());
    bus1.mult  = bus0.mult;
    bus0.shift = SH'($urandom());
    bus1.shift = bus0.shift;
  endtask

  function automatic longint act_of(input logic [N-1:0][ACT-1:0] v, input int i);
    return longint'($signed(v[i]));
  endfunction

  task automatic check_results(input string tag);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("%s.relu%0d.act%0d", tag, r, i),
            act_of((r == 0) ? bus0.act_out : bus1.act_out, i), exp_act[r][i]);
      end
      chk($sformatf("%s.relu%0d.max_idx", tag, r),
          longint'((r == 0) ? bus0.max_idx : bus1.max_idx), exp_idx[r]);
      chk($sformatf("%s.relu%0d.max_val", tag, r),
          longint'($signed((r == 0) ? bus0.max_val : bus1.max_val)), exp_val[r]);
    end
  endtask

  // Issues one run from cur_* and returns in the done cycle; operands are scrambled
  // right after the start edge so capture is exercised on every run.
  task automatic do_run(input string tag, output int unsigned done_cyc);
    int n;
    bit busy_ok;
    compute_expected();
    drive_inputs();
    bus0.start = 1'b1;
    bus1.start = 1'b1;
    step();
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    scramble_inputs();
    n       = 0;
    busy_ok = 1'b1;
    while (bus0.done !== 1'b1 && n < 20) begin
      if (bus0.busy !== 1'b1 || bus1.busy !== 1'b1) busy_ok = 1'b0;
      step();
      n++;
    end
    done_cyc = cyc;
    chk({tag, ".latency"}, n, N + 1);
    chk({tag, ".busy_during_run"}, longint'(busy_ok), 1);
    chk({tag, ".done_relu1"}, longint'(bus1.done), 1);
    chk({tag, ".busy_at_done"}, longint'(bus0.busy | bus1.busy), 0);
    check_results(tag);
  endtask

  task automatic idle_gap(input string tag);
    step();
    chk({tag, ".done_pulse"}, longint'(bus0.done | bus1.done), 0);
    step();
  endtask

  task automatic set_acc(input longint a0, input longint a1, input longint a2, input longint a3);
    cur_acc[0] = a0;
    cur_acc[1] = a1;
    cur_acc[2] = a2;
    cur_acc[3] = a3;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, ".busy"}, longint'(bus0.busy | bus1.busy), 0);
    chk({tag, ".done"}, longint'(bus0.done | bus1.done), 0);
    chk({tag, ".act0"}, longint'(bus0.act_out), 0);
    chk({tag, ".act1"}, longint'(bus1.act_out), 0);
    chk({tag, ".max"}, longint'({bus0.max_idx, bus0.max_val, bus1.max_idx, bus1.max_val}), 0);
  endtask

  initial begin
    int unsigned d1, d2;
    rst_n      = 1'b0;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    cur_mult   = 0;
    cur_shift  = 0;
    set_acc(0, 0, 0, 0);
    drive_inputs();
    step();
    step();
    check_cleared("reset");
    rst_n = 1'b1;
    step();

    // Basic rounding, with and without ReLU.
    set_acc(1000, 1004, -12, 8);
    cur_mult  = 1;
    cur_shift = 3;
    do_run("round", d1);
    chk("round.hand.act2", act_of(bus0.act_out, 2), -1);
    chk("round.hand.act1", act_of(bus0.act_out, 1), 126);
    chk("round.hand.relu_act2", act_of(bus1.act_out, 2), 0);
    idle_gap("round");

    // All negative: ReLU zeros everything, argmax stays at 0.
    set_acc(-20, -5, -1, -100);
    do_run("neg", d1);
    chk("neg.hand.relu_idx", longint'(bus1.max_idx), 0);
    idle_gap("neg");

    // Saturation with shift 0, tie keeps lowest index.
    set_acc(100000, -100000, 127, -128);
    cur_shift = 0;
    do_run("sat", d1);
    chk("sat.hand.act1", act_of(bus0.act_out, 1), -128);
    chk("sat.hand.max_idx", longint'(bus0.max_idx), 0);
    idle_gap("sat");

    // Multiplier path.
    set_acc(3, -7, 0, 50);
    cur_mult  = 300;
    cur_shift = 8;
    do_run("mult", d1);
    chk("mult.hand.act1", act_of(bus0.act_out, 1), -8);
    chk("mult.hand.act3", act_of(bus0.act_out, 3), 59);
    idle_gap("mult");

    // Back-to-back: second start issued in the first run's done cycle.
    set_acc(400, -300, 2000, 7);
    cur_mult  = 5;
    cur_shift = 4;
    do_run("b2b_a", d1);
    set_acc(-9, 88, 88, -1000);
    cur_mult  = 2;
    cur_shift = 1;
    do_run("b2b_b", d2);
    chk("b2b.period", longint'(d2 - d1), N + 2);
    idle_gap("b2b");

    // Reset two cycles into a run discards everything.
    set_acc(5000, 6000, -7000, 8000);
    cur_mult  = 3;
    cur_shift = 5;
    drive_inputs();
    bus0.start = 1'b1;
    bus1.start = 1'b1;
    step();
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    check_cleared("midrst");
    rst_n = 1'b1;
    step();
    do_run("after_rst", d1);
    idle_gap("after_rst");

    // Shift far beyond the product width collapses to the sign.
    set_acc(5, 100000, -7, 2000000000);
    cur_mult  = 65535;
    cur_shift = 63;
    do_run("bigshift", d1);
    cur_shift = 49;
    do_run("shift49", d1);
    idle_gap("bigshift");

    // Randomized runs, sometimes back-to-back.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N; i++) begin
        cur_acc[i] = longint'($signed($urandom())) >>> $urandom_range(0, 31);
      end
      cur_mult  = longint'($urandom_range(0, 65535));
      cur_shift = $urandom_range(0, 49);
      do_run($sformatf("rand%0d", t), d1);
      if ($urandom_range(0, 1) == 1) idle_gap($sformatf("rand%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
